// File: rtl/preset_tick_counter.sv
// preset_tick_counter
//   Programmable prescaler that emits a one-cycle clock-enable strobe
//   (tick_o) every div_ratio+1 enabled cycles. Each strobe advances an
//   up/down modulo counter that runs over 0..LIMIT and returns to PRESET
//   after reset or a preset pulse. Everything stays on the single clock.
//
// Ports
//   clock     in   1      sole clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   enable    in   1      prescaler runs when 1, holds when 0
//   div_ratio in   DIV_W  tick period minus one
//   down      in   1      counting direction, sampled on tick edges only
//   preset    in   1      count <= PRESET, prescaler <= 0
//   load      in   1      count <= min(load_val, LIMIT)
//   load_val  in   CNT_W  value for load
//   tick_o    out  1      one-cycle strobe per prescaler period
//   count_o   out  CNT_W  counter value
//   wrap_o    out  1      one-cycle strobe when the counter wraps
module preset_tick_counter #(
  parameter int unsigned DIV_W  = 4,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned LIMIT  = 31,
  parameter int unsigned PRESET = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             down,
  input  logic             preset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] PRESET_C = CNT_W'(PRESET);
  localparam logic [CNT_W-1:0] ZERO_C   = '0;

  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] load_sat_c;

  // Loaded value clamped to the terminal value.
  assign load_sat_c = (load_val > LIMIT_C) ? LIMIT_C : load_val;

  // Prescaler next state. The >= compare lets a lowered div_ratio end the
  // current period on the very next edge instead of running past it.
  always_comb begin
    pcnt_d = pcnt_q;
    tick_d = 1'b0;
    if (preset) begin
      pcnt_d = '0;
    end else if (enable) begin
      if (pcnt_q >= div_ratio) begin
        pcnt_d = '0;
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + DIV_W'(1);
      end
    end
  end

  // Counter next state: preset > load > tick. tick_d is the tick event, so
  // count_o moves on the same edge that raises tick_o.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (preset) begin
      count_d = PRESET_C;
    end else if (load) begin
      count_d = load_sat_c;
    end else if (tick_d) begin
      if (down) begin
        if (count_q == ZERO_C) begin
          count_d = LIMIT_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end else begin
        if (count_q == LIMIT_C) begin
          count_d = ZERO_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      count_q <= PRESET_C;
      wrap_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tick_o  = tick_q;
  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_preset_tick_counter.sv
// Directed bench for preset_tick_counter: a default instance (LIMIT=31) and a
// saturating instance (LIMIT=20) share all inputs.
module tb_preset_tick_counter;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [3:0] div_ratio;
  logic       down;
  logic       preset;
  logic       load;
  logic [4:0] load_val;
  logic       tick_o,  wrap_o;
  logic [4:0] count_o;
  logic       s_tick,  s_wrap;
  logic [4:0] s_count;

  int n_vec = 0;
  int n_err = 0;

  preset_tick_counter u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .div_ratio(div_ratio),
    .down(down), .preset(preset), .load(load), .load_val(load_val),
    .tick_o(tick_o), .count_o(count_o), .wrap_o(wrap_o)
  );

  preset_tick_counter #(.DIV_W(4), .CNT_W(5), .LIMIT(20), .PRESET(9)) u_sat (
    .clock(clock), .reset_n(reset_n), .enable(enable), .div_ratio(div_ratio),
    .down(down), .preset(preset), .load(load), .load_val(load_val),
    .tick_o(s_tick), .count_o(s_count), .wrap_o(s_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs are then sampled at the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk3(input string tag, input logic t, input logic [4:0] c, input logic w);
    chk({tag, ".tick"},  {31'd0, tick_o}, {31'd0, t});
    chk({tag, ".count"}, {27'd0, count_o}, {27'd0, c});
    chk({tag, ".wrap"},  {31'd0, wrap_o}, {31'd0, w});
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; div_ratio = 4'd3; down = 1'b0;
    preset = 1'b0; load = 1'b0; load_val = 5'd0;

    // Asynchronous reset, checked before any clock edge
    #1 reset_n = 1'b0;
    #1;
    chk3("reset", 1'b0, 5'd9, 1'b0);
    chk("reset.sat_count", {27'd0, s_count}, 32'd9);
    @(negedge clock);
    reset_n = 1'b1;

    // Divide by 4, counting up from PRESET
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk3($sformatf("div4[%0d]", i), (i % 4) == 3, 5'(9 + (i + 1) / 4), 1'b0);
    end

    // Hold: advance prescaler to 2, freeze 5 cycles, then it resumes from 2
    step(); step();
    chk3("pre_hold", 1'b0, 5'd11, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk3($sformatf("hold[%0d]", i), 1'b0, 5'd11, 1'b0);
    end
    enable = 1'b1;
    step();
    chk3("resume0", 1'b0, 5'd11, 1'b0);
    step();
    chk3("resume1", 1'b1, 5'd12, 1'b0);

    // Resize: pcnt reaches 6 under div 9, then div 2 ends the period at once
    div_ratio = 4'd9;
    for (int i = 0; i < 6; i++) step();
    chk3("div9_pcnt6", 1'b0, 5'd12, 1'b0);
    div_ratio = 4'd2;
    step();
    chk3("resize", 1'b1, 5'd13, 1'b0);

    // Wrap up through LIMIT
    load = 1'b1; load_val = 5'd30;
    step();
    chk3("load30", 1'b0, 5'd30, 1'b0);
    load = 1'b0; div_ratio = 4'd0;
    step();
    chk3("up31", 1'b1, 5'd31, 1'b0);
    step();
    chk3("wrap_up", 1'b1, 5'd0, 1'b1);
    step();
    chk3("after_wrap", 1'b1, 5'd1, 1'b0);

    // Load drops the same-edge tick; then wrap down through zero
    load = 1'b1; load_val = 5'd0;
    step();
    chk3("load0", 1'b1, 5'd0, 1'b0);
    load = 1'b0; down = 1'b1;
    step();
    chk3("wrap_down", 1'b1, 5'd31, 1'b1);
    step();
    chk3("down30", 1'b1, 5'd30, 1'b0);

    // Priority: preset beats load and the tick, and clears the prescaler
    preset = 1'b1; load = 1'b1; load_val = 5'd5;
    step();
    chk3("preset_prio", 1'b0, 5'd9, 1'b0);
    preset = 1'b0; load = 1'b0; down = 1'b0; div_ratio = 4'd3;
    step(); step(); step();
    chk3("post_preset3", 1'b0, 5'd9, 1'b0);
    step();
    chk3("post_preset4", 1'b1, 5'd10, 1'b0);

    // Load at and beyond the smaller instance's LIMIT
    load = 1'b1; load_val = 5'd31;
    step();
    chk3("load31", 1'b0, 5'd31, 1'b0);
    chk("load31.sat_count", {27'd0, s_count}, 32'd20);
    load_val = 5'd25;
    step();
    chk3("load25", 1'b0, 5'd25, 1'b0);
    chk("load25.sat_count", {27'd0, s_count}, 32'd20);
    load = 1'b0; div_ratio = 4'd0;
    step();
    chk3("tick_after25", 1'b1, 5'd26, 1'b0);
    chk("sat_wrap.count", {27'd0, s_count}, 32'd0);
    chk("sat_wrap.wrap", {31'd0, s_wrap}, 32'd1);
    chk("sat_wrap.tick", {31'd0, s_tick}, 32'd1);

    // Mid-period reset discards the partial prescale count
    div_ratio = 4'd3;
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    chk3("mid_reset", 1'b0, 5'd9, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step(); step(); step();
    chk3("post_reset3", 1'b0, 5'd9, 1'b0);
    step();
    chk3("post_reset4", 1'b1, 5'd10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
